// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg: shared state type, response status codes and small helpers
// for the rggen local-bus arbiters.
package rggen_rtl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rggen_state_e;

  localparam logic [1:0] RGGEN_STATUS_OK    = 2'b00;
  localparam logic [1:0] RGGEN_STATUS_ERROR = 2'b10;

  // Bit j of RGGEN_INDEX_MASK[b] is set when host index j has bit b set;
  // used to turn a one-hot grant (up to 8 hosts) into a binary index.
  localparam logic [2:0][7:0] RGGEN_INDEX_MASK = {8'hF0, 8'hCC, 8'hAA};

  // Watchdog counter width: wide enough for the limit, kept within 8..16 bits.
  function automatic int unsigned rggen_watchdog_width(int unsigned limit);
    int unsigned width;
    width = $clog2(limit + 1);
    if (width < 8) begin
      width = 8;
    end
    if (width > 16) begin
      width = 16;
    end
    return width;
  endfunction

endpackage

// File: rtl/rggen_command_arbiter_if.sv
// rggen_command_arbiter_if: host-side request bundle, downstream command port
// and downstream response for rggen_command_arbiter.
// slave  = arbiter view, master = requesters/decoder view.
interface rggen_command_arbiter_if #(
  parameter int HOSTS         = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
);

  localparam int STROBE_WIDTH = DATA_WIDTH / 8;

  // per-host requests
  logic [HOSTS-1:0]                     i_command_valid;
  logic [HOSTS-1:0]                     i_write;
  logic [HOSTS-1:0]                     i_read;
  logic [HOSTS-1:0][ADDRESS_WIDTH-1:0]  i_address;
  logic [HOSTS-1:0][STROBE_WIDTH-1:0]   i_strobe;
  logic [HOSTS-1:0][DATA_WIDTH-1:0]     i_write_data;

  // per-host response
  logic [HOSTS-1:0]                     o_response_ready;
  logic [DATA_WIDTH-1:0]                o_read_data;
  logic [1:0]                           o_status;

  // downstream command
  logic                                 o_command_valid;
  logic                                 o_write;
  logic                                 o_read;
  logic [ADDRESS_WIDTH-1:0]             o_address;
  logic [STROBE_WIDTH-1:0]              o_strobe;
  logic [DATA_WIDTH-1:0]                o_write_data;
  logic [DATA_WIDTH-1:0]                o_write_mask;

  // downstream response
  logic                                 i_response_ready;
  logic [DATA_WIDTH-1:0]                i_read_data;
  logic [1:0]                           i_status;

  modport slave (
    input  i_command_valid, i_write, i_read, i_address, i_strobe, i_write_data,
    output o_response_ready, o_read_data, o_status,
    output o_command_valid, o_write, o_read, o_address, o_strobe,
    output o_write_data, o_write_mask,
    input  i_response_ready, i_read_data, i_status
  );

  modport master (
    output i_command_valid, i_write, i_read, i_address, i_strobe, i_write_data,
    input  o_response_ready, o_read_data, o_status,
    input  o_command_valid, o_write, o_read, o_address, o_strobe,
    input  o_write_data, o_write_mask,
    output i_response_ready, i_read_data, i_status
  );

endinterface

// File: rtl/rggen_round_robin_selector.sv
// rggen_round_robin_selector: combinational round-robin pick. Returns the
// one-hot winner among the requests, searching upward from last_grant+1 and
// wrapping to host 0. Zero requests give a zero winner.
module rggen_round_robin_selector #(
  parameter int HOSTS = 2
)(
  input  logic [HOSTS-1:0]         request,
  input  logic [$clog2(HOSTS)-1:0] last_grant,
  output logic [HOSTS-1:0]         winner
);

  localparam int INDEX_WIDTH = $clog2(HOSTS);
  localparam logic [HOSTS-1:0] LSB = HOSTS'(1);

  // requests strictly above last_grant take priority over the wrapped ones
  logic [HOSTS-1:0] upper;

  for (genvar j = 0; j < HOSTS; j++) begin : g_upper
    assign upper[j] = request[j] && (INDEX_WIDTH'(j) > last_grant);
  end

  // Lowest set bit of the upper set, else lowest set bit of all requests.
  always_comb begin
    if (|upper) begin
      winner = upper & (~upper + LSB);
    end else begin
      winner = request & (~request + LSB);
    end
  end

endmodule

// File: rtl/rggen_command_arbiter.sv
// rggen_command_arbiter: shares the local command port of a register block
// among HOSTS requesters. Round-robin grant, one command in flight, response
// routed back to the granted host only.
// Optional response watchdog: define RGGEN_COMMAND_ARBITER_WATCHDOG_EN.
module rggen_command_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int HOSTS          = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic                  clk,
  input  logic                  rst,
  rggen_command_arbiter_if.slave bus
);

  localparam int INDEX_WIDTH  = $clog2(HOSTS);
  localparam int STROBE_WIDTH = DATA_WIDTH / 8;
  localparam logic [HOSTS-1:0] ONE_HOT_0 = HOSTS'(1);

  rggen_state_e             state;
  rggen_state_e             next_state;
  logic [INDEX_WIDTH-1:0]   grant;
  logic [INDEX_WIDTH-1:0]   last_grant;
  logic [INDEX_WIDTH-1:0]   next_grant;
  logic [HOSTS-1:0]         winner;
  logic [HOSTS-1:0]         grant_onehot;
  logic                     start;
  logic                     timed_out;

  logic                     sel_write;
  logic                     sel_read;
  logic [ADDRESS_WIDTH-1:0] sel_address;
  logic [STROBE_WIDTH-1:0]  sel_strobe;
  logic [DATA_WIDTH-1:0]    sel_write_data;
  logic [DATA_WIDTH-1:0]    sel_write_mask;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  assign start = (state == IDLE) && (|bus.i_command_valid);

  rggen_round_robin_selector #(
    .HOSTS (HOSTS)
  ) u_selector (
    .request    (bus.i_command_valid),
    .last_grant (last_grant),
    .winner     (winner)
  );

  for (genvar b = 0; b < INDEX_WIDTH; b++) begin : g_index
    assign next_grant[b] = |(winner & RGGEN_INDEX_MASK[b][HOSTS-1:0]);
  end

  assign grant_onehot = ONE_HOT_0 << grant;

  // Latch the winner on the IDLE cycle that sees a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= INDEX_WIDTH'(HOSTS - 1);
    end else if (start) begin
      grant      <= next_grant;
      last_grant <= next_grant;
    end
  end

  // ---------------------------------------------------------------------
  // Response watchdog
  // ---------------------------------------------------------------------
`ifdef RGGEN_COMMAND_ARBITER_WATCHDOG_EN
  localparam int WATCHDOG_WIDTH = rggen_watchdog_width(TIMEOUT_CYCLES);

  logic [WATCHDOG_WIDTH-1:0] watchdog_count;

  // Counts BUSY cycles without a response; zero outside BUSY so each grant starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      watchdog_count <= '0;
    end else if (state != BUSY) begin
      watchdog_count <= '0;
    end else if (!bus.i_response_ready) begin
      watchdog_count <= watchdog_count + WATCHDOG_WIDTH'(1);
    end
  end

  assign timed_out = (state == BUSY) &&
                     (watchdog_count == WATCHDOG_WIDTH'(TIMEOUT_CYCLES));
`else
  assign timed_out = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: grant on any request, release on response or timeout.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (bus.i_response_ready || timed_out) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Command mux from the granted host
  // ---------------------------------------------------------------------
  assign sel_write      = bus.i_write[grant];
  assign sel_read       = bus.i_read[grant];
  assign sel_address    = bus.i_address[grant];
  assign sel_strobe     = bus.i_strobe[grant];
  assign sel_write_data = bus.i_write_data[grant];

  for (genvar i = 0; i < STROBE_WIDTH; i++) begin : g_mask
    assign sel_write_mask[8*i+:8] = {8{sel_strobe[i]}};
  end

  // Outputs: command and response are live only in BUSY; a timeout replaces
  // the downstream response with an error pulse and withdraws the command.
  always_comb begin
    bus.o_command_valid  = 1'b0;
    bus.o_write          = 1'b0;
    bus.o_read           = 1'b0;
    bus.o_address        = '0;
    bus.o_strobe         = '0;
    bus.o_write_data     = '0;
    bus.o_write_mask     = '0;
    bus.o_response_ready = '0;
    bus.o_read_data      = '0;
    bus.o_status         = RGGEN_STATUS_OK;
    if (state == BUSY) begin
      if (timed_out) begin
        bus.o_response_ready = grant_onehot;
        bus.o_status         = RGGEN_STATUS_ERROR;
      end else begin
        bus.o_command_valid  = 1'b1;
        bus.o_write          = sel_write;
        bus.o_read           = sel_read;
        bus.o_address        = sel_address;
        bus.o_strobe         = sel_strobe;
        bus.o_write_data     = sel_write_data;
        bus.o_write_mask     = sel_write_mask;
        bus.o_response_ready = bus.i_response_ready ? grant_onehot : '0;
        bus.o_read_data      = bus.i_read_data;
        bus.o_status         = bus.i_status;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Simulation checks
  // ---------------------------------------------------------------------
  // A granted host must keep its request up until its response pulse.
  property p_hold_request;
    @(posedge clk) disable iff (rst)
      (state == BUSY) |-> bus.i_command_valid[grant];
  endproperty

  a_hold_request: assert property (p_hold_request)
    else $error("rggen_command_arbiter: granted host dropped its request");

  if (HOSTS < 2 || HOSTS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_invalid_config
    // Only elaborated for an unsupported parameter set.
    always_ff @(posedge clk) begin
      assert (1'b0) else $error("rggen_command_arbiter: unsupported parameters");
    end
  end

endmodule
